// File: rtl/t02_ball_position_calc.sv
// t02_ball_position_calc
// Scans the 8x5 ball-sensor matrix row by row, accumulates covered sensors,
// and once per frame publishes the rounded centroid plus a ball-present flag.
// The frame length is fixed by SETTLE_CYCLES and does not depend on content.
// Optional feature macro: T02_POS_FILTER_EN (per-axis jump limiter of +/-1 per
// frame while a ball is already being tracked).
module t02_ball_position_calc #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MISS_LIMIT    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic [4:0] col_in,
    output logic [7:0] row_sel,
    output logic [3:0] x_pos_calc,
    output logic [3:0] y_pos_calc,
    output logic       ball_detected,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_ROW    = 2'd0,
        ST_DIV    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [3:0] MISS_LIM    = 4'(MISS_LIMIT);
    // Each axis takes one quotient bit per tick over a 10-bit dividend.
    localparam logic [4:0] DIV_X_LAST  = 5'd9;
    localparam logic [4:0] DIV_Y_LAST  = 5'd19;

    // Number of covered sensors in one row readback.
    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] n;
        n = '0;
        for (int j = 0; j < 5; j++) begin
            n = n + {2'b00, v[j]};
        end
        return n;
    endfunction

    // Sum of the column indices of the covered sensors (max 0+1+2+3+4 = 10).
    function automatic logic [3:0] colsum5(input logic [4:0] v);
        logic [3:0] s;
        s = '0;
        for (int j = 0; j < 5; j++) begin
            if (v[j]) begin
                s = s + 4'(j);
            end
        end
        return s;
    endfunction

`ifdef T02_POS_FILTER_EN
    // Move one step from cur toward tgt, or hold when already there.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        logic [3:0] r;
        if (tgt > cur) begin
            r = cur + 4'd1;
        end else if (tgt < cur) begin
            r = cur - 4'd1;
        end else begin
            r = cur;
        end
        return r;
    endfunction
`endif

    // Column synchronizer
    logic [4:0] col_s1_q, col_s2_q;

    // Control and accumulator state
    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [3:0] settle_q, settle_d;
    logic [5:0] count_q, count_d;
    logic [8:0] sum_x_q, sum_x_d;
    logic [6:0] sum_y_q, sum_y_d;
    logic [4:0] div_cnt_q, div_cnt_d;
    logic [3:0] miss_q, miss_d;

    // Divider datapath: dvd holds the dividend and shifts quotient bits in
    logic [9:0] dvd_q, dvd_d;
    logic [6:0] rem_q, rem_d;
    logic [3:0] x_calc_q, x_calc_d;
    logic [3:0] y_calc_q, y_calc_d;

    // Published outputs
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic       det_q, det_d;
    logic       fd_q, fd_d;

    // Per-row sample contribution
    logic [2:0] row_pop;
    logic [3:0] row_csum;
    logic [5:0] row_weight;

    assign row_pop    = popcount5(col_s2_q);
    assign row_csum   = colsum5(col_s2_q);
    assign row_weight = {3'b000, row_q} * {3'b000, row_pop};

    // One restoring-division step. An empty frame forces the divisor to 1 so
    // the datapath stays well-defined; its result is ignored in UPDATE.
    logic [6:0] divisor;
    logic [7:0] trial;
    logic       trial_ge;
    logic [6:0] rem_sub;
    logic [9:0] quo_step;

    assign divisor  = (count_q == 6'd0) ? 7'd1 : {count_q, 1'b0};
    assign trial    = {rem_q, dvd_q[9]};
    assign trial_ge = (trial >= {1'b0, divisor});
    // When trial >= divisor the true difference is below the divisor (<= 80),
    // so the low 7 bits carry it exactly.
    assign rem_sub  = trial[6:0] - divisor;
    assign quo_step = {dvd_q[8:0], trial_ge};

    // Two-flop synchronizer on the asynchronous column readback, every clk
    always_ff @(posedge clk) begin
        col_s1_q <= col_in;
        col_s2_q <= col_s1_q;
    end

    // Control, accumulator and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ROW;
            row_q     <= 3'd0;
            settle_q  <= 4'd0;
            count_q   <= 6'd0;
            sum_x_q   <= 9'd0;
            sum_y_q   <= 7'd0;
            div_cnt_q <= 5'd0;
            miss_q    <= 4'd0;
            x_q       <= 4'd0;
            y_q       <= 4'd0;
            det_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            settle_q  <= settle_d;
            count_q   <= count_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            div_cnt_q <= div_cnt_d;
            miss_q    <= miss_d;
            x_q       <= x_d;
            y_q       <= y_d;
            det_q     <= det_d;
            fd_q      <= fd_d;
        end
    end

    // Divider datapath registers; always loaded before they are used
    always_ff @(posedge clk) begin
        dvd_q    <= dvd_d;
        rem_q    <= rem_d;
        x_calc_q <= x_calc_d;
        y_calc_q <= y_calc_d;
    end

    // Next-state logic: row scan, division sequence and frame update
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        settle_d  = settle_q;
        count_d   = count_q;
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        div_cnt_d = div_cnt_q;
        miss_d    = miss_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        x_calc_d  = x_calc_q;
        y_calc_d  = y_calc_q;
        x_d       = x_q;
        y_d       = y_q;
        det_d     = det_q;
        fd_d      = 1'b0;

        if (clk_en) begin
            case (state_q)
                ST_ROW: begin
                    if (settle_q == SETTLE_LAST) begin
                        count_d  = count_q + {3'b000, row_pop};
                        sum_x_d  = sum_x_q + {3'b000, row_weight};
                        sum_y_d  = sum_y_q + {3'b000, row_csum};
                        settle_d = 4'd0;
                        if (row_q == 3'd7) begin
                            // Prime the X axis with the totals including row 7
                            state_d   = ST_DIV;
                            div_cnt_d = 5'd0;
                            dvd_d     = {sum_x_d, 1'b0} + {4'b0000, count_d};
                            rem_d     = 7'd0;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end

                ST_DIV: begin
                    dvd_d     = quo_step;
                    rem_d     = trial_ge ? rem_sub : trial[6:0];
                    div_cnt_d = div_cnt_q + 5'd1;
                    if (div_cnt_q == DIV_X_LAST) begin
                        // X quotient complete; start the Y axis
                        x_calc_d = quo_step[3:0];
                        dvd_d    = {2'b00, sum_y_q, 1'b0} + {4'b0000, count_q};
                        rem_d    = 7'd0;
                    end
                    if (div_cnt_q == DIV_Y_LAST) begin
                        y_calc_d = quo_step[3:0];
                        state_d  = ST_UPDATE;
                    end
                end

                ST_UPDATE: begin
                    if (count_q != 6'd0) begin
`ifdef T02_POS_FILTER_EN
                        if (det_q) begin
                            x_d = step_toward(x_q, x_calc_q);
                            y_d = step_toward(y_q, y_calc_q);
                        end else begin
                            x_d = x_calc_q;
                            y_d = y_calc_q;
                        end
`else
                        x_d = x_calc_q;
                        y_d = y_calc_q;
`endif
                        det_d  = 1'b1;
                        miss_d = 4'd0;
                    end else begin
                        miss_d = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;
                        if (miss_d >= MISS_LIM) begin
                            det_d = 1'b0;
                        end
                    end
                    fd_d     = 1'b1;
                    count_d  = 6'd0;
                    sum_x_d  = 9'd0;
                    sum_y_d  = 7'd0;
                    row_d    = 3'd0;
                    settle_d = 4'd0;
                    state_d  = ST_ROW;
                end

                default: begin
                    state_d = ST_ROW;
                end
            endcase
        end
    end

    assign row_sel       = 8'd1 << row_q;
    assign x_pos_calc    = x_q;
    assign y_pos_calc    = y_q;
    assign ball_detected = det_q;
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_t02_ball_position_calc.sv
// Testbench for t02_ball_position_calc: a board model answers row_sel with
// the selected row's columns; results are checked per frame against a table
// of hand-derived vectors, hand-written corner sequences and a reference model.
module tb_t02_ball_position_calc;

    localparam int SETTLE      = 4;
    localparam int MISS        = 3;
    localparam int FRAME_TICKS = 8 * (SETTLE + 1) + 21;
`ifdef T02_POS_FILTER_EN
    localparam bit FIL = 1'b1;
`else
    localparam bit FIL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [4:0]  col_in;
    logic [7:0]  row_sel;
    logic [3:0]  x_pos_calc;
    logic [3:0]  y_pos_calc;
    logic        ball_detected;
    logic        frame_done;
    logic [39:0] board;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    t02_ball_position_calc #(
        .SETTLE_CYCLES(SETTLE),
        .MISS_LIMIT   (MISS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .col_in       (col_in),
        .row_sel      (row_sel),
        .x_pos_calc   (x_pos_calc),
        .y_pos_calc   (y_pos_calc),
        .ball_detected(ball_detected),
        .frame_done   (frame_done)
    );

    // Physical board: sensor (r,c) is bit r*5+c
    function automatic logic [4:0] board_row(input logic [39:0] b, input logic [7:0] rs);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (rs[i]) r = r | b[i*5 +: 5];
        end
        return r;
    endfunction

    assign col_in = board_row(board, row_sel);

    function automatic logic [39:0] rect(input int r0, input int r1, input int c0, input int c1);
        logic [39:0] v;
        v = '0;
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                v[r*5+c] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model state: published results as the spec defines them
    int m_x, m_y, m_miss;
    bit m_det;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_miss = 0; m_det = 1'b0;
    endtask

    task automatic model_frame(input logic [39:0] b);
        int c, sx, sy, cx, cy;
        c = 0; sx = 0; sy = 0;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 5; k++)
                if (b[r*5+k]) begin
                    c++; sx += r; sy += k;
                end
        if (c > 0) begin
            cx = (2 * sx + c) / (2 * c);
            cy = (2 * sy + c) / (2 * c);
            if (FIL && m_det) begin
                m_x += (cx > m_x) ? 1 : (cx < m_x) ? -1 : 0;
                m_y += (cy > m_y) ? 1 : (cy < m_y) ? -1 : 0;
            end else begin
                m_x = cx; m_y = cy;
            end
            m_det = 1'b1;
            m_miss = 0;
        end else begin
            if (m_miss < 15) m_miss++;
            if (m_miss >= MISS) m_det = 1'b0;
        end
    endtask

    task automatic do_reset();
        clk_en = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Run one full frame from its first tick; returns ticks consumed
    task automatic run_frame(input logic [39:0] b, input int en_pct, output int ticks, output bit done);
        board = b;
        ticks = 0;
        done  = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            clk_en = ($urandom_range(0, 99) < en_pct);
            @(posedge clk);
            #1;
            if (clk_en) ticks++;
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
        clk_en = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        logic [39:0] b;
        int          ex;
        int          ey;
        bit          edet;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [39:0] b, input int ex, input int ey,
                       input bit edet, input string name);
        vec_t v;
        v.rst = rst; v.b = b; v.ex = ex; v.ey = ey; v.edet = edet; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ticks, cnt;
        bit  done, fd_seen;
        logic [63:0] rnd;
        logic [39:0] b;

        rst_n  = 1'b1;
        clk_en = 1'b1;
        board  = '0;

        // Hand-derived vectors; filter-dependent values come from the build
        add(1'b1, rect(5, 5, 3, 3), 5, 3, 1'b1, "single_5_3");
        add(1'b1, rect(2, 3, 1, 2), 3, 2, 1'b1, "blob_2x2");
        add(1'b1, rect(0, 7, 0, 4), 4, 2, 1'b1, "full_board");
        add(1'b1, rect(6, 6, 1, 1), 6, 1, 1'b1, "track_6_1");
        add(1'b0, '0,               6, 1, 1'b1, "empty1");
        add(1'b0, '0,               6, 1, 1'b1, "empty2");
        add(1'b0, rect(6, 6, 1, 1), 6, 1, 1'b1, "rehit");
        add(1'b0, '0,               6, 1, 1'b1, "empty1b");
        add(1'b0, '0,               6, 1, 1'b1, "empty2b");
        add(1'b0, '0,               6, 1, 1'b0, "empty3b_lost");
        add(1'b1, rect(1, 1, 2, 2), 1, 2, 1'b1, "track_1_2");
        add(1'b0, rect(6, 6, 2, 2), FIL ? 2 : 6, 2, 1'b1, "jump1");
        add(1'b0, rect(6, 6, 2, 2), FIL ? 3 : 6, 2, 1'b1, "jump2");
        add(1'b0, rect(6, 6, 2, 2), FIL ? 4 : 6, 2, 1'b1, "jump3");
        add(1'b0, rect(6, 6, 2, 2), FIL ? 5 : 6, 2, 1'b1, "jump4");
        add(1'b0, rect(6, 6, 2, 2), 6, 2, 1'b1, "jump5");

        // Reset values, asserted asynchronously mid-cycle
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_row_sel", row_sel, 8'h01);
        check("rst_x", x_pos_calc, 0);
        check("rst_y", y_pos_calc, 0);
        check("rst_det", ball_detected, 0);
        check("rst_frame_done", frame_done, 0);

        // Row walk: each row held SETTLE+1 ticks, then result at tick 61
        board = rect(5, 5, 3, 3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 40; t++) begin
            check($sformatf("walk_row_sel_t%0d", t), row_sel, 1 << (t / (SETTLE + 1)));
            check($sformatf("walk_fd_t%0d", t), frame_done, 0);
            @(posedge clk);
            #1;
        end
        cnt = 40;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
        check("walk_done", done, 1);
        check("walk_ticks", cnt, FRAME_TICKS);
        check("walk_x", x_pos_calc, 5);
        check("walk_y", y_pos_calc, 3);
        check("walk_det", ball_detected, 1);
        @(posedge clk);
        #1;
        check("walk_fd_one_cycle", frame_done, 0);

        // Table-driven frames
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            run_frame(tbl[i].b, 100, ticks, done);
            check({tbl[i].name, "_done"}, done, 1);
            check({tbl[i].name, "_ticks"}, ticks, FRAME_TICKS);
            check({tbl[i].name, "_x"}, x_pos_calc, tbl[i].ex);
            check({tbl[i].name, "_y"}, y_pos_calc, tbl[i].ey);
            check({tbl[i].name, "_det"}, ball_detected, tbl[i].edet);
        end

        // Freeze mid-row 4; board noise during the freeze must not be sampled
        do_reset();
        board = rect(3, 4, 0, 1);
        repeat (22) begin
            @(posedge clk);
            #1;
        end
        clk_en = 1'b0;
        fd_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2)  board = {40{1'b1}};
            if (i == 10) board = rect(3, 4, 0, 1);
            @(posedge clk);
            #1;
            if (frame_done) fd_seen = 1'b1;
        end
        check("freeze_row_sel", row_sel, 8'h10);
        check("freeze_no_fd", fd_seen, 0);
        clk_en = 1'b1;
        cnt = 22;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
        check("freeze_done", done, 1);
        check("freeze_ticks", cnt, FRAME_TICKS);
        check("freeze_x", x_pos_calc, 4);
        check("freeze_y", y_pos_calc, 1);
        check("freeze_det", ball_detected, 1);

        // Reset mid-DIV clears outputs immediately; next frame is full length
        repeat (45) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("divrst_row_sel", row_sel, 8'h01);
        check("divrst_x", x_pos_calc, 0);
        check("divrst_y", y_pos_calc, 0);
        check("divrst_det", ball_detected, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(rect(2, 2, 4, 4), 100, ticks, done);
        check("divrst_done", done, 1);
        check("divrst_ticks", ticks, FRAME_TICKS);
        check("divrst_x_after", x_pos_calc, 2);
        check("divrst_y_after", y_pos_calc, 4);
        check("divrst_det_after", ball_detected, 1);

        // Randomized boards and clk_en gaps against the reference model
        do_reset();
        model_reset();
        for (int f = 0; f < 40; f++) begin
            rnd = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0, 1: b = '0;
                2:    b = rect($urandom_range(0, 7), 7, $urandom_range(0, 4), 4) &
                          rect(0, $urandom_range(0, 7), 0, $urandom_range(0, 4));
                3:    b = rnd[39:0];
                default: b = rnd[39:0] & rnd[63:24];
            endcase
            run_frame(b, $urandom_range(50, 100), ticks, done);
            model_frame(b);
            check($sformatf("rnd%0d_done", f), done, 1);
            check($sformatf("rnd%0d_ticks", f), ticks, FRAME_TICKS);
            check($sformatf("rnd%0d_x", f), x_pos_calc, m_x);
            check($sformatf("rnd%0d_y", f), y_pos_calc, m_y);
            check($sformatf("rnd%0d_det", f), ball_detected, m_det);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
